// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NumReq valid/ready byte producers.
// Optional macro UART_ARB_TAG_EN: each grant sends tag byte {4'hA, grant id} before the payload.
module uart_tx_arbiter #(
  parameter  int NumReq  = 4,
  localparam int IdWidth = $clog2(NumReq)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumReq-1:0]   req_valid_i,
  input  logic [NumReq*8-1:0] req_data_i,
  output logic [NumReq-1:0]   req_ready_o,
  output logic                start_tx_o,
  output logic [7:0]          tx_data_o,
  input  logic                tx_done_tick_i,
  output logic                tx_busy_o,
  output logic [IdWidth-1:0]  grant_id_o
);

`ifdef UART_ARB_TAG_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_WAIT, ST_TAG_START, ST_TAG_WAIT} state_e;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_WAIT} state_e;
`endif

  state_e               state_q, state_d;
  logic [IdWidth-1:0]   ptr_q, ptr_d;
  logic                 start_q, start_d;
  logic [7:0]           data_q, data_d;
  logic                 busy_q, busy_d;
  logic [IdWidth-1:0]   gid_q, gid_d;
`ifdef UART_ARB_TAG_EN
  logic [7:0]           payload_q, payload_d;
`endif

  logic [7:0]           req_bytes [NumReq];
  logic [IdWidth-1:0]   winner;
  logic                 found;
  logic [7:0]           win_data;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_bytes
    assign req_bytes[gi] = req_data_i[8*gi +: 8];
  end

  // Scan ptr, ptr+1, ... wrapping; the first valid requester wins.
  always_comb begin
    logic [IdWidth:0]   sum;
    logic [IdWidth-1:0] idx;
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NumReq; k++) begin
      sum = {1'b0, ptr_q} + (IdWidth+1)'(k);
      if (sum >= (IdWidth+1)'(NumReq)) sum = sum - (IdWidth+1)'(NumReq);
      idx = sum[IdWidth-1:0];
      if (!found && req_valid_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign win_data = req_bytes[winner];

  always_comb begin
    req_ready_o = '0;
    if (state_q == ST_IDLE && found) begin
      req_ready_o = {{(NumReq-1){1'b0}}, 1'b1} << winner;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    start_d   = 1'b0;
    data_d    = data_q;
    busy_d    = busy_q;
    gid_d     = gid_q;
`ifdef UART_ARB_TAG_EN
    payload_d = payload_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          gid_d   = winner;
          busy_d  = 1'b1;
          start_d = 1'b1;
`ifdef UART_ARB_TAG_EN
          payload_d = win_data;
          data_d    = {4'hA, 4'(winner)};
          state_d   = ST_TAG_START;
`else
          data_d  = win_data;
          state_d = ST_START;
`endif
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (tx_done_tick_i) begin
          ptr_d   = (gid_q == IdWidth'(NumReq-1)) ? '0 : gid_q + 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
`ifdef UART_ARB_TAG_EN
      ST_TAG_START: state_d = ST_TAG_WAIT;
      ST_TAG_WAIT: begin
        // Tag is out; the payload follows through the normal start/wait pair.
        if (tx_done_tick_i) begin
          data_d  = payload_q;
          start_d = 1'b1;
          state_d = ST_START;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      start_q   <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      gid_q     <= '0;
`ifdef UART_ARB_TAG_EN
      payload_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      start_q   <= start_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      gid_q     <= gid_d;
`ifdef UART_ARB_TAG_EN
      payload_q <= payload_d;
`endif
    end
  end

  assign start_tx_o = start_q;
  assign tx_data_o  = data_q;
  assign tx_busy_o  = busy_q;
  assign grant_id_o = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised self-checking bench for uart_tx_arbiter against a round-robin reference model.
module tb_uart_tx_arbiter;
  localparam int N = 4;
`ifdef UART_ARB_TAG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [N-1:0]  req_valid_i = '0;
  logic [N*8-1:0] req_data_i = '0;
  logic [N-1:0]  req_ready_o;
  logic          start_tx_o;
  logic [7:0]    tx_data_o;
  logic          tx_done_tick_i = 1'b0;
  logic          tx_busy_o;
  logic [1:0]    grant_id_o;

  int test_cnt = 0;
  int fail_cnt = 0;
  int ptr_m = 0;

  uart_tx_arbiter #(.NumReq(N)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .start_tx_o(start_tx_o), .tx_data_o(tx_data_o), .tx_done_tick_i(tx_done_tick_i),
    .tx_busy_o(tx_busy_o), .grant_id_o(grant_id_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: first valid index found from the pointer, wrapping around.
  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Drives one grant from a negedge+1 alignment and reports what was observed.
  task automatic run_grant(input logic [N-1:0] m, input logic [N*8-1:0] d,
                           output logic [N-1:0] rdy, output logic [7:0] b_first,
                           output logic [7:0] b_last, output logic [1:0] gid,
                           output int starts, output logic hold_ok, output logic busy_end);
    logic [7:0] cur;
    req_valid_i = m;
    req_data_i  = d;
    #1;
    rdy = req_ready_o;
    starts = 0;
    hold_ok = 1'b1;
    b_first = '0;
    b_last = '0;
    gid = '0;
    for (int b = 0; b < NB; b++) begin
      @(negedge clk_i);
      tx_done_tick_i = 1'b0;
      req_valid_i = '0;
      #1;
      if (start_tx_o) starts++;
      cur = tx_data_o;
      if (b == 0) b_first = cur;
      b_last = cur;
      gid = grant_id_o;
      if (!tx_busy_o || req_ready_o !== '0) hold_ok = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk_i);
        #1;
        if (start_tx_o || !tx_busy_o || tx_data_o !== cur || grant_id_o !== gid || req_ready_o !== '0)
          hold_ok = 1'b0;
      end
      tx_done_tick_i = 1'b1;
    end
    @(negedge clk_i);
    tx_done_tick_i = 1'b0;
    #1;
    busy_end = tx_busy_o;
    if (start_tx_o) hold_ok = 1'b0;
  endtask

  logic [N-1:0] rdy;
  logic [7:0]   bf, bl;
  logic [1:0]   gid;
  int           starts;
  logic         hold_ok, busy_end;

  task automatic test_reset();
    logic [N*8-1:0] d;
    repeat (2) @(negedge clk_i);
    #1;
    test_cnt++;
    if ({start_tx_o, tx_busy_o, tx_data_o, grant_id_o, req_ready_o} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_outputs got start=%b busy=%b data=%h gid=%0d rdy=%b want all 0",
               start_tx_o, tx_busy_o, tx_data_o, grant_id_o, req_ready_o);
    end
    rst_ni = 1'b1;
    d = {$urandom, $urandom};
    run_grant(4'b0100, d, rdy, bf, bl, gid, starts, hold_ok, busy_end);
    ptr_m = 3;
    req_valid_i = 4'b1000;
    req_data_i = {$urandom};
    @(negedge clk_i);
    req_valid_i = '0;
    @(negedge clk_i);
    #1;
    test_cnt++;
    if (tx_busy_o !== 1'b1 || grant_id_o !== 2'd3) begin
      fail_cnt++;
      $display("FAIL reset_pre_wait got busy=%b gid=%0d want busy=1 gid=3", tx_busy_o, grant_id_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    test_cnt++;
    if ({start_tx_o, tx_busy_o, tx_data_o, grant_id_o, req_ready_o} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_mid_wait got start=%b busy=%b data=%h gid=%0d rdy=%b want all 0",
               start_tx_o, tx_busy_o, tx_data_o, grant_id_o, req_ready_o);
    end
    ptr_m = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    d = {$urandom, $urandom};
    run_grant(4'b1111, d, rdy, bf, bl, gid, starts, hold_ok, busy_end);
    test_cnt++;
    if (gid !== 2'd0 || rdy !== 4'b0001) begin
      fail_cnt++;
      $display("FAIL reset_ptr got gid=%0d rdy=%b want gid=0 rdy=0001", gid, rdy);
    end
    ptr_m = 1;
    $display("[TB] reset: mid-frame abort, pointer back to 0");
  endtask

  task automatic test_single();
    logic [N*8-1:0] d;
    d = {$urandom, $urandom};
    d[23:16] = 8'h5A;
    run_grant(4'b0100, d, rdy, bf, bl, gid, starts, hold_ok, busy_end);
    test_cnt++;
    if (rdy !== 4'b0100 || gid !== 2'd2 || bl !== 8'h5A) begin
      fail_cnt++;
      $display("FAIL single got rdy=%b gid=%0d data=%h want rdy=0100 gid=2 data=5a", rdy, gid, bl);
    end
    test_cnt++;
    if (starts !== NB || !hold_ok || busy_end !== 1'b0) begin
      fail_cnt++;
      $display("FAIL single_proto got starts=%0d hold=%b busy_end=%b want starts=%0d hold=1 busy_end=0",
               starts, hold_ok, busy_end, NB);
    end
    ptr_m = 3;
    $display("[TB] single: req2 byte %h gid %0d", bl, gid);
  endtask

  task automatic test_round_robin();
    logic [N*8-1:0] d;
    int w;
    for (int i = 0; i < 5; i++) begin
      d = {$urandom, $urandom};
      w = pick(4'b1111, ptr_m);
      run_grant(4'b1111, d, rdy, bf, bl, gid, starts, hold_ok, busy_end);
      test_cnt++;
      if (int'(gid) !== w || rdy !== 4'(1 << w) || bl !== d[8*w +: 8]) begin
        fail_cnt++;
        $display("FAIL rr[%0d] got gid=%0d rdy=%b data=%h want gid=%0d data=%h",
                 i, gid, rdy, bl, w, d[8*w +: 8]);
      end
      test_cnt++;
      if (starts !== NB || !hold_ok || busy_end !== 1'b0) begin
        fail_cnt++;
        $display("FAIL rr_proto[%0d] got starts=%0d hold=%b busy_end=%b", i, starts, hold_ok, busy_end);
      end
      ptr_m = (w + 1) % N;
      $display("[TB] rr: grant %0d data %h", gid, bl);
    end
  endtask

  task automatic test_wrap();
    logic [N*8-1:0] d;
    d = {$urandom, $urandom};
    run_grant(4'b1000, d, rdy, bf, bl, gid, starts, hold_ok, busy_end);
    test_cnt++;
    if (gid !== 2'd3) begin
      fail_cnt++;
      $display("FAIL wrap_first got gid=%0d want 3", gid);
    end
    run_grant(4'b1010, d, rdy, bf, bl, gid, starts, hold_ok, busy_end);
    test_cnt++;
    if (gid !== 2'd1 || rdy !== 4'b0010 || bl !== d[15:8]) begin
      fail_cnt++;
      $display("FAIL wrap got gid=%0d rdy=%b data=%h want gid=1 rdy=0010 data=%h", gid, rdy, bl, d[15:8]);
    end
    ptr_m = 2;
    $display("[TB] wrap: after 3 granted %0d", gid);
  endtask

  task automatic test_stray_done();
    logic [N*8-1:0] d;
    int w;
    tx_done_tick_i = 1'b1;
    @(negedge clk_i);
    tx_done_tick_i = 1'b0;
    #1;
    test_cnt++;
    if (tx_busy_o !== 1'b0 || start_tx_o !== 1'b0) begin
      fail_cnt++;
      $display("FAIL stray_done got busy=%b start=%b want 0 0", tx_busy_o, start_tx_o);
    end
    d = {$urandom, $urandom};
    w = pick(4'b1111, ptr_m);
    run_grant(4'b1111, d, rdy, bf, bl, gid, starts, hold_ok, busy_end);
    test_cnt++;
    if (int'(gid) !== w) begin
      fail_cnt++;
      $display("FAIL stray_ptr got gid=%0d want %0d", gid, w);
    end
    ptr_m = (w + 1) % N;
    $display("[TB] stray done ignored, next grant %0d", gid);
  endtask

  task automatic test_random();
    logic [N*8-1:0] d;
    logic [N-1:0] m;
    logic [7:0] ef;
    int w;
    for (int i = 0; i < 30; i++) begin
      m = 4'($urandom_range(0, 15));
      d = {$urandom, $urandom};
      if (m == '0) begin
        req_valid_i = '0;
        #1;
        test_cnt++;
        if (req_ready_o !== '0) begin
          fail_cnt++;
          $display("FAIL rand_idle[%0d] got rdy=%b want 0000", i, req_ready_o);
        end
        @(negedge clk_i);
        #1;
        continue;
      end
      w = pick(m, ptr_m);
      ef = (NB == 2) ? (8'hA0 | 8'(w)) : d[8*w +: 8];
      run_grant(m, d, rdy, bf, bl, gid, starts, hold_ok, busy_end);
      test_cnt++;
      if (int'(gid) !== w || rdy !== 4'(1 << w) || bl !== d[8*w +: 8] || bf !== ef) begin
        fail_cnt++;
        $display("FAIL rand[%0d] m=%b got gid=%0d rdy=%b bytes=%h,%h want gid=%0d bytes=%h,%h",
                 i, m, gid, rdy, bf, bl, w, ef, d[8*w +: 8]);
      end
      test_cnt++;
      if (starts !== NB || !hold_ok || busy_end !== 1'b0) begin
        fail_cnt++;
        $display("FAIL rand_proto[%0d] got starts=%0d hold=%b busy_end=%b", i, starts, hold_ok, busy_end);
      end
      ptr_m = (w + 1) % N;
      $display("[TB] rand[%0d] mask %b grant %0d data %h", i, m, gid, bl);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_stray_done();
    test_random();
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
